// File: rtl/lut_pkg.sv
// Shared definitions for the LUT stream reader: table geometry, FSM state
// encoding and the fixed table image (word[i] = 2*i).
// No ports; imported by lut_table and lut_stream_reader.
package lut_pkg;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned DATA_W   = 4;
    localparam int unsigned ADDR_W   = $clog2(DEPTH);
    localparam int unsigned LUT_STEP = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Table word for any index; also used when the table is built with a
    // non-default geometry.
    function automatic int unsigned lut_word(input int unsigned idx);
        return LUT_STEP * idx;
    endfunction

    function automatic logic [DEPTH-1:0][DATA_W-1:0] lut_init();
        logic [DEPTH-1:0][DATA_W-1:0] t;
        for (int i = 0; i < int'(DEPTH); i++) begin
            t[i] = DATA_W'(lut_word(i));
        end
        return t;
    endfunction

    // Table image for the default geometry.
    localparam logic [DEPTH-1:0][DATA_W-1:0] LUT_INIT = lut_init();

endpackage

// File: rtl/lut_table.sv
// Read-only lookup table holding word[i] = 2*i; combinational read.
// Ports: addr_i (table index), data_o (word at addr_i).
// Contents are constants; there is no write port.
module lut_table
    import lut_pkg::*;
#(
    parameter int unsigned DEPTH  = lut_pkg::DEPTH,
    parameter int unsigned DATA_W = lut_pkg::DATA_W,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]     addr_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] rom [DEPTH];

    if (DEPTH == lut_pkg::DEPTH && DATA_W == lut_pkg::DATA_W) begin : g_default
        for (genvar i = 0; i < int'(DEPTH); i++) begin : g_word
            assign rom[i] = LUT_INIT[i];
        end
    end else begin : g_custom
        for (genvar i = 0; i < int'(DEPTH); i++) begin : g_word
            assign rom[i] = DATA_W'(lut_word(i));
        end
    end

    assign data_o = rom[addr_i];

endmodule

// File: rtl/lut_stream_reader.sv
// Streams a burst of consecutive table words (address wraps modulo DEPTH)
// over a valid/ready port; first word one cycle after start, no bubbles.
// Ports: start/start_addr/count request, abort cancel, m_* stream, busy, done.
// Optional macro LUT_STREAM_LOOP_EN adds input loop: the burst repeats until
// abort or reset. Outputs hold while m_valid=1 and m_ready=0.
module lut_stream_reader
    import lut_pkg::*;
#(
    parameter int unsigned DEPTH  = lut_pkg::DEPTH,
    parameter int unsigned DATA_W = lut_pkg::DATA_W,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     start_addr,
    input  logic [CW-1:0]     count,
    input  logic              abort,
`ifdef LUT_STREAM_LOOP_EN
    input  logic              loop,
`endif
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [CW-1:0]     rem_q, rem_d;     // words left, including the one presented
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
`ifdef LUT_STREAM_LOOP_EN
    logic [AW-1:0]     base_q, base_d;
    logic [CW-1:0]     len_q, len_d;
    logic              loop_q, loop_d;
`endif

    lut_table #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_table (
        .addr_i (rd_addr),
        .data_o (rd_data)
    );

    // Table is read one step ahead so the next word is registered on the
    // accepting edge: the request address in IDLE, otherwise addr+1
    // (or the burst base when a looping burst wraps to its first word).
    always_comb begin
        rd_addr = addr_q + AW'(1);
        if (state_q == ST_IDLE) begin
            rd_addr = start_addr;
        end
`ifdef LUT_STREAM_LOOP_EN
        else if (last_q) begin
            rd_addr = base_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        last_d  = last_q;
`ifdef LUT_STREAM_LOOP_EN
        base_d  = base_q;
        len_d   = len_q;
        loop_d  = loop_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_d = ST_STREAM;
                        addr_d  = start_addr;
                        rem_d   = count;
                        data_d  = rd_data;
                        last_d  = (count == CW'(1));
`ifdef LUT_STREAM_LOOP_EN
                        base_d  = start_addr;
                        len_d   = count;
                        loop_d  = loop;
`endif
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_STREAM: begin
                // abort wins over a handshake in the same cycle
                if (abort) begin
                    state_d = ST_IDLE;
                    data_d  = '0;
                    last_d  = 1'b0;
                end else if (m_ready) begin
                    if (last_q) begin
`ifdef LUT_STREAM_LOOP_EN
                        if (loop_q) begin
                            addr_d = base_q;
                            rem_d  = len_q;
                            data_d = rd_data;
                            last_d = (len_q == CW'(1));
                        end else begin
                            state_d = ST_DONE;
                            data_d  = '0;
                            last_d  = 1'b0;
                        end
`else
                        state_d = ST_DONE;
                        data_d  = '0;
                        last_d  = 1'b0;
`endif
                    end else begin
                        addr_d = addr_q + AW'(1);
                        rem_d  = rem_q - CW'(1);
                        data_d = rd_data;
                        last_d = (rem_q == CW'(2));
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
`ifdef LUT_STREAM_LOOP_EN
            base_q  <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            last_q  <= last_d;
`ifdef LUT_STREAM_LOOP_EN
            base_q  <= base_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
`endif
        end
    end

    assign m_valid = (state_q == ST_STREAM);
    assign m_data  = data_q;
    assign m_last  = last_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_lut_stream_reader.sv
// Bench for lut_stream_reader: burst table with a word scoreboard, plus
// hand-written reset, abort-in-idle, mid-burst reset and loop sequences.
module tb_lut_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, m_ready;
    logic [2:0] start_addr;
    logic [3:0] count;
    logic       m_valid, m_last, busy, done;
    logic [3:0] m_data;
`ifdef LUT_STREAM_LOOP_EN
    logic       loop;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lut_stream_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .abort      (abort),
`ifdef LUT_STREAM_LOOP_EN
        .loop       (loop),
`endif
        .m_ready    (m_ready),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [3:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        logic [2:0] sa;
        logic [3:0] cnt;
        int         stall;        // cycles m_ready is held low on the first word
        int         abort_after;  // abort after this many handshakes (0 = none)
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference table: word[i] = 2*i, address taken modulo 8.
    function automatic logic [3:0] word_at(input int a);
        return 4'(2 * (a % 8));
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        int   n_exp, stall, hs, guard;
        exp_t e;
        n_exp = (v.abort_after > 0) ? v.abort_after : int'(v.cnt);
        for (int k = 0; k < n_exp; k++) begin
            e.data = word_at(int'(v.sa) + k);
            e.last = (k == int'(v.cnt) - 1);
            sb.push_back(e);
        end
        start = 1'b1; start_addr = v.sa; count = v.cnt;
        @(negedge clk);
        start = 1'b0;
        if (v.cnt == 4'd0) begin
            chk($sformatf("v%0d_zero_valid", id), m_valid, 0);
            chk($sformatf("v%0d_zero_done", id), done, 1);
            @(negedge clk);
            chk($sformatf("v%0d_zero_done_clr", id), done, 0);
            chk($sformatf("v%0d_zero_valid2", id), m_valid, 0);
            chk($sformatf("v%0d_zero_idle", id), busy, 0);
            return;
        end
        stall = v.stall; hs = 0; guard = 0;
        while (hs < n_exp && guard < 100) begin
            chk($sformatf("v%0d_valid_w%0d", id, hs), m_valid, 1);
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL v%0d_sb_empty: got empty scoreboard expected pending word", id);
                break;
            end
            chk($sformatf("v%0d_data_w%0d", id, hs), m_data, sb[0].data);
            chk($sformatf("v%0d_last_w%0d", id, hs), m_last, sb[0].last);
            m_ready = (stall == 0);
            if (stall > 0) stall--;
            if (v.abort_after > 0 && hs == 1) begin
                // request while busy; must not disturb the burst
                start = 1'b1; start_addr = 3'd0; count = 4'd1;
            end
            @(negedge clk);
            start = 1'b0;
            if (m_ready) begin
                void'(sb.pop_front());
                hs++;
            end
            guard++;
        end
        if (guard >= 100) begin
            checks++; errors++;
            $display("FAIL v%0d_timeout: got %0d handshakes expected %0d", id, hs, n_exp);
        end
        if (v.abort_after > 0) begin
            chk($sformatf("v%0d_pre_abort_data", id), m_data, word_at(int'(v.sa) + n_exp));
            abort = 1'b1; m_ready = 1'b1;
            @(negedge clk);
            abort = 1'b0; m_ready = 1'b0;
            chk($sformatf("v%0d_abort_valid", id), m_valid, 0);
            chk($sformatf("v%0d_abort_busy", id), busy, 0);
            chk($sformatf("v%0d_abort_done", id), done, 0);
            @(negedge clk);
            chk($sformatf("v%0d_abort_done2", id), done, 0);
        end else begin
            m_ready = 1'b0;
            chk($sformatf("v%0d_end_valid", id), m_valid, 0);
            chk($sformatf("v%0d_end_done", id), done, 1);
            chk($sformatf("v%0d_end_busy", id), busy, 1);
            @(negedge clk);
            chk($sformatf("v%0d_end_done_clr", id), done, 0);
            chk($sformatf("v%0d_end_idle", id), busy, 0);
        end
        chk($sformatf("v%0d_sb_drained", id), sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        vecs[0] = '{3'd2, 4'd3, 0, 0};   // 4,6,8
        vecs[1] = '{3'd6, 4'd4, 0, 0};   // 12,14,0,2 wrap
        vecs[2] = '{3'd0, 4'd2, 3, 0};   // stall on first word
        vecs[3] = '{3'd5, 4'd0, 0, 0};   // empty burst
        vecs[4] = '{3'd1, 4'd5, 0, 2};   // abort after two words
        vecs[5] = '{3'd7, 4'd8, 1, 0};   // full-depth wrap
        vecs[6] = '{3'd3, 4'd1, 0, 0};   // single word

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
        start_addr = '0; count = '0;
`ifdef LUT_STREAM_LOOP_EN
        loop = 1'b0;
`endif
        @(negedge clk);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // abort while idle is ignored, including alongside start
        abort = 1'b1;
        @(negedge clk);
        chk("idle_abort_busy", busy, 0);
        start = 1'b1; start_addr = 3'd4; count = 4'd1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("idle_abort_start_valid", m_valid, 1);
        chk("idle_abort_start_data", m_data, word_at(4));
        chk("idle_abort_start_last", m_last, 1);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("idle_abort_start_done", done, 1);
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
            @(negedge clk);
        end

        // reset in the middle of a burst
        start = 1'b1; start_addr = 3'd2; count = 4'd8; m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_rst_pre_data", m_data, word_at(3));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_data", m_data, 0);
        chk("mid_rst_last", m_last, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_done_c%0d", i), done, 0);
            chk($sformatf("post_rst_busy_c%0d", i), busy, 0);
        end
        m_ready = 1'b0;

`ifdef LUT_STREAM_LOOP_EN
        // looping burst repeats words 3,4 of the table until aborted
        start = 1'b1; start_addr = 3'd3; count = 4'd2; loop = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; loop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("loop_valid_%0d", i), m_valid, 1);
            chk($sformatf("loop_data_%0d", i), m_data, word_at(3 + (i % 2)));
            chk($sformatf("loop_last_%0d", i), m_last, (i % 2) == 1);
            chk($sformatf("loop_done_%0d", i), done, 0);
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; m_ready = 1'b0;
        chk("loop_abort_valid", m_valid, 0);
        chk("loop_abort_busy", busy, 0);
        chk("loop_abort_done", done, 0);
        start = 1'b1; start_addr = 3'd3; count = 4'd2; loop = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; loop = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("loop2_wrap_data", m_data, word_at(3));
        #2 rst_n = 1'b0;
        #1;
        chk("loop_rst_valid", m_valid, 0);
        chk("loop_rst_data", m_data, 0);
        chk("loop_rst_last", m_last, 0);
        chk("loop_rst_busy", busy, 0);
        chk("loop_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1; m_ready = 1'b0;
        @(negedge clk);
        chk("loop_post_rst_done", done, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
